hpdcache_flush_sequencer: RTL and testbench

//  Sequences fence-driven maintenance of the HPDcache data cache: it blocks new load/store issue, drains
//  in-flight loads and the write buffer, optionally issues a cache flush and then an invalidate, and

---
 rtl/hpdcache_flush_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_hpdcache_flush_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_flush_sequencer.sv
// Fence maintenance sequencer for the HPDcache: blocks issue, drains loads and
// the write buffer, optionally flushes then invalidates, and acknowledges the fence.
module hpdcache_flush_sequencer #(
  parameter bit          FlushEn        = 1'b0,
  parameter bit          InvalidateEn   = 1'b0,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TimeoutCycles  = 4096,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fence_req_i,
  output logic                fence_ack_o,
  output logic                fence_err_o,
  output logic                busy_o,
  output logic                issue_block_o,
  input  logic                ld_req_fire_i,
  input  logic                ld_rsp_fire_i,
  input  logic                wbuf_empty_i,
  output logic                flush_valid_o,
  input  logic                flush_ready_i,
  input  logic                flush_done_i,
  output logic                inval_valid_o,
  input  logic                inval_ready_i,
  input  logic                inval_done_i,
  output logic                cnt_err_o,
  output logic [CntWidth-1:0] fence_cnt_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned TmrW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH_REQ,
    S_FLUSH_WAIT,
    S_INV_REQ,
    S_INV_WAIT,
    S_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [OutW-1:0]     outst_q, outst_d;
  logic                cnt_err_q, cnt_err_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic                err_q, err_d;
  logic [CntWidth-1:0] fence_cnt_q, fence_cnt_d;
  logic                busy_q, busy_d;
  logic                block_q, block_d;
  logic                flush_valid_q, flush_valid_d;
  logic                inval_valid_q, inval_valid_d;
  logic                ack_q, ack_d;
  logic                fence_err_q, fence_err_d;

  logic                drained;
  logic                timed_out;
  logic                in_wait;
  state_e              after_drain;
  state_e              after_flush;

  assign drained     = (outst_q == '0) && wbuf_empty_i;
  assign timed_out   = (timer_q == TmrW'(TimeoutCycles - 1));
  assign in_wait     = (state_q == S_DRAIN) || (state_q == S_FLUSH_WAIT) ||
                       (state_q == S_INV_WAIT);
  assign after_flush = InvalidateEn ? S_INV_REQ : S_ACK;
  assign after_drain = FlushEn ? S_FLUSH_REQ : after_flush;

  // In-flight load tracking with saturating bounds and a sticky error flag
  always_comb begin
    outst_d   = outst_q;
    cnt_err_d = cnt_err_q;
    if (ld_req_fire_i && !ld_rsp_fire_i) begin
      if (outst_q == OutW'(MaxOutstanding)) cnt_err_d = 1'b1;
      else                                  outst_d   = outst_q + OutW'(1);
    end else if (ld_rsp_fire_i && !ld_req_fire_i) begin
      if (outst_q == '0) cnt_err_d = 1'b1;
      else               outst_d   = outst_q - OutW'(1);
    end
  end

  // Next-state, watchdog, fence counter and next registered outputs
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    fence_cnt_d = fence_cnt_q;
    timer_d     = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (fence_req_i) begin
          state_d = S_DRAIN;
          err_d   = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = after_drain;
        end else if (timed_out) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end
      end
      S_FLUSH_REQ: begin
        if (flush_ready_i) state_d = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (flush_done_i) begin
          state_d = after_flush;
        end else if (timed_out) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end
      end
      S_INV_REQ: begin
        if (inval_ready_i) state_d = S_INV_WAIT;
      end
      S_INV_WAIT: begin
        if (inval_done_i) begin
          state_d = S_ACK;
        end else if (timed_out) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase

    if (state_d != state_q) timer_d = '0;
    else if (in_wait)       timer_d = timer_q + TmrW'(1);

    if ((state_d == S_ACK) && (state_q != S_ACK)) fence_cnt_d = fence_cnt_q + CntWidth'(1);

    busy_d        = (state_d != S_IDLE);
    block_d       = (state_d != S_IDLE);
    flush_valid_d = (state_d == S_FLUSH_REQ);
    inval_valid_d = (state_d == S_INV_REQ);
    ack_d         = (state_d == S_ACK);
    fence_err_d   = (state_d == S_ACK) && err_d;
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      outst_q       <= '0;
      cnt_err_q     <= 1'b0;
      timer_q       <= '0;
      err_q         <= 1'b0;
      fence_cnt_q   <= '0;
      busy_q        <= 1'b0;
      block_q       <= 1'b0;
      flush_valid_q <= 1'b0;
      inval_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      fence_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      outst_q       <= outst_d;
      cnt_err_q     <= cnt_err_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      fence_cnt_q   <= fence_cnt_d;
      busy_q        <= busy_d;
      block_q       <= block_d;
      flush_valid_q <= flush_valid_d;
      inval_valid_q <= inval_valid_d;
      ack_q         <= ack_d;
      fence_err_q   <= fence_err_d;
    end
  end

  assign fence_ack_o   = ack_q;
  assign fence_err_o   = fence_err_q;
  assign busy_o        = busy_q;
  assign issue_block_o = block_q;
  assign flush_valid_o = flush_valid_q;
  assign inval_valid_o = inval_valid_q;
  assign cnt_err_o     = cnt_err_q;
  assign fence_cnt_o   = fence_cnt_q;

endmodule

// File: tb/tb_hpdcache_flush_sequencer.sv
// Bench for hpdcache_flush_sequencer: three configurations share the cache-side
// stimulus, each compared every cycle against a phase-list reference model.
module tb_hpdcache_flush_sequencer;

  localparam int P_MAX [3] = '{8, 4, 2};
  localparam int P_TO  [3] = '{64, 64, 16};
  localparam int P_CW  [3] = '{16, 16, 2};
  localparam int P_FL  [3] = '{0, 1, 1};
  localparam int P_IN  [3] = '{0, 1, 0};

  localparam int PH_DRAIN = 0, PH_FREQ = 1, PH_FWAIT = 2, PH_IREQ = 3, PH_IWAIT = 4, PH_ACK = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic       ld_req = 1'b0, ld_rsp = 1'b0, wbuf = 1'b0;
  logic       fr = 1'b0, fd = 1'b0, ir = 1'b0, idn = 1'b0;

  wire [2:0]  ack_w, ferr_w, busy_w, blk_w, fv_w, iv_w, cerr_w;
  wire [15:0] cnt0, cnt1;
  wire [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hpdcache_flush_sequencer #(.FlushEn(1'b0), .InvalidateEn(1'b0), .MaxOutstanding(8),
    .TimeoutCycles(64), .CntWidth(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .fence_req_i(req[0]), .fence_ack_o(ack_w[0]),
    .fence_err_o(ferr_w[0]), .busy_o(busy_w[0]), .issue_block_o(blk_w[0]),
    .ld_req_fire_i(ld_req), .ld_rsp_fire_i(ld_rsp), .wbuf_empty_i(wbuf),
    .flush_valid_o(fv_w[0]), .flush_ready_i(fr), .flush_done_i(fd),
    .inval_valid_o(iv_w[0]), .inval_ready_i(ir), .inval_done_i(idn),
    .cnt_err_o(cerr_w[0]), .fence_cnt_o(cnt0));

  hpdcache_flush_sequencer #(.FlushEn(1'b1), .InvalidateEn(1'b1), .MaxOutstanding(4),
    .TimeoutCycles(64), .CntWidth(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .fence_req_i(req[1]), .fence_ack_o(ack_w[1]),
    .fence_err_o(ferr_w[1]), .busy_o(busy_w[1]), .issue_block_o(blk_w[1]),
    .ld_req_fire_i(ld_req), .ld_rsp_fire_i(ld_rsp), .wbuf_empty_i(wbuf),
    .flush_valid_o(fv_w[1]), .flush_ready_i(fr), .flush_done_i(fd),
    .inval_valid_o(iv_w[1]), .inval_ready_i(ir), .inval_done_i(idn),
    .cnt_err_o(cerr_w[1]), .fence_cnt_o(cnt1));

  hpdcache_flush_sequencer #(.FlushEn(1'b1), .InvalidateEn(1'b0), .MaxOutstanding(2),
    .TimeoutCycles(16), .CntWidth(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .fence_req_i(req[2]), .fence_ack_o(ack_w[2]),
    .fence_err_o(ferr_w[2]), .busy_o(busy_w[2]), .issue_block_o(blk_w[2]),
    .ld_req_fire_i(ld_req), .ld_rsp_fire_i(ld_rsp), .wbuf_empty_i(wbuf),
    .flush_valid_o(fv_w[2]), .flush_ready_i(fr), .flush_done_i(fd),
    .inval_valid_o(iv_w[2]), .inval_ready_i(ir), .inval_done_i(idn),
    .cnt_err_o(cerr_w[2]), .fence_cnt_o(cnt2));

  // Reference model: each fence is a list of phases walked front to back
  int plan [3][6];
  int plen [3] = '{0, 0, 0};
  int pidx [3] = '{0, 0, 0};
  bit act  [3] = '{0, 0, 0};
  int age  [3] = '{0, 0, 0};
  bit merr [3] = '{0, 0, 0};
  int mout [3] = '{0, 0, 0};
  bit mcerr[3] = '{0, 0, 0};
  int mcnt [3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_phase(input int k, input int ph);
    plan[k][plen[k]] = ph;
    plen[k] = plen[k] + 1;
  endtask

  task automatic model_step(input int k);
    bit done;
    int ph;
    int old_out;
    if (!rst_n) begin
      act[k] = 0; age[k] = 0; merr[k] = 0; mout[k] = 0; mcerr[k] = 0; mcnt[k] = 0;
      return;
    end
    old_out = mout[k];
    if (ld_req && !ld_rsp) begin
      if (mout[k] == P_MAX[k]) mcerr[k] = 1; else mout[k] = mout[k] + 1;
    end else if (ld_rsp && !ld_req) begin
      if (mout[k] == 0) mcerr[k] = 1; else mout[k] = mout[k] - 1;
    end
    if (!act[k]) begin
      if (req[k]) begin
        plen[k] = 0;
        add_phase(k, PH_DRAIN);
        if (P_FL[k] != 0) begin add_phase(k, PH_FREQ); add_phase(k, PH_FWAIT); end
        if (P_IN[k] != 0) begin add_phase(k, PH_IREQ); add_phase(k, PH_IWAIT); end
        add_phase(k, PH_ACK);
        act[k] = 1; pidx[k] = 0; age[k] = 0; merr[k] = 0;
      end
      return;
    end
    ph = plan[k][pidx[k]];
    if (ph == PH_ACK) begin
      act[k] = 0;
      return;
    end
    case (ph)
      PH_DRAIN: done = (old_out == 0) && wbuf;
      PH_FREQ:  done = fr;
      PH_FWAIT: done = fd;
      PH_IREQ:  done = ir;
      default:  done = idn;
    endcase
    if (done) begin
      pidx[k] = pidx[k] + 1; age[k] = 0;
    end else if ((ph == PH_DRAIN || ph == PH_FWAIT || ph == PH_IWAIT) && age[k] == P_TO[k] - 1) begin
      pidx[k] = plen[k] - 1; merr[k] = 1; age[k] = 0;
    end else begin
      age[k] = age[k] + 1;
    end
    if (plan[k][pidx[k]] == PH_ACK) mcnt[k] = (mcnt[k] + 1) % (1 << P_CW[k]);
  endtask

  function automatic logic [15:0] cnt_of(input int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      default: return {14'b0, cnt2};
    endcase
  endfunction

  function automatic logic [22:0] got_vec(input int k);
    return {busy_w[k], blk_w[k], fv_w[k], iv_w[k], ack_w[k], ferr_w[k], cerr_w[k], cnt_of(k)};
  endfunction

  function automatic logic [22:0] exp_vec(input int k);
    int  ph;
    logic a;
    ph = act[k] ? plan[k][pidx[k]] : -1;
    a  = (ph == PH_ACK);
    return {act[k], act[k], ph == PH_FREQ, ph == PH_IREQ, a, a && merr[k], mcerr[k], 16'(mcnt[k])};
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("dut%0d_outputs", k), 64'(got_vec(k)), 64'(exp_vec(k)));
  endtask

  initial begin
    int ack_cyc, cnt_at_ack, acks, fv_cyc, err_at_ack;
    bit quiet;

    // Reset state
    repeat (2) tick();
    check("reset_outputs_dut0", 64'(got_vec(0)), 64'h0);
    check("reset_outputs_dut1", 64'(got_vec(1)), 64'h0);

    // Minimum latency, no flush/invalidate
    rst_n = 1'b1; wbuf = 1'b1; req[0] = 1'b1;
    ack_cyc = -1; cnt_at_ack = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack_w[0]) begin
        if (ack_cyc < 0) begin ack_cyc = c + 1; cnt_at_ack = int'(cnt0); end
        req[0] = 1'b0;
      end
    end
    check("min_latency_ack_cycle", 64'(ack_cyc), 64'd2);
    check("min_latency_fence_cnt", 64'(cnt_at_ack), 64'd1);

    // Three loads in flight, responses at +4, +6, +9
    ld_req = 1'b1;
    repeat (3) tick();
    ld_req = 1'b0; req[0] = 1'b1; ack_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      ld_rsp = (c == 4) || (c == 6) || (c == 9);
      tick();
      if (c + 1 == 5) check("drain_issue_block", 64'(blk_w[0]), 64'd1);
      if (ack_w[0]) begin
        if (ack_cyc < 0) ack_cyc = c + 1;
        req[0] = 1'b0;
      end
    end
    ld_rsp = 1'b0;
    check("drain_ack_cycle", 64'(ack_cyc), 64'd11);

    // Flush then invalidate with delayed ready and done
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req[1] = 1'b1; ir = 1'b1; acks = 0; fv_cyc = 0; ack_cyc = -1; err_at_ack = 0;
    for (int c = 0; c < 50; c++) begin
      fr  = (c == 7);
      fd  = (c == 27);
      idn = (c == 39);
      tick();
      if (fv_w[1]) fv_cyc++;
      if (ack_w[1]) begin
        acks++;
        ack_cyc = c + 1;
        err_at_ack = int'(ferr_w[1]);
        req[1] = 1'b0;
      end
    end
    fr = 1'b0; fd = 1'b0; ir = 1'b0; idn = 1'b0;
    check("flush_valid_cycles", 64'(fv_cyc), 64'd6);
    check("flush_inval_ack_count", 64'(acks), 64'd1);
    check("flush_inval_ack_cycle", 64'(ack_cyc), 64'd40);
    check("flush_inval_err", 64'(err_at_ack), 64'd0);

    // Reset during flush wait aborts without ack and clears the counter
    fr = 1'b1; req[1] = 1'b1;
    repeat (6) tick();
    check("pre_reset_in_flush_wait", 64'({busy_w[1], fv_w[1]}), 64'b10);
    rst_n = 1'b0;
    tick();
    check("mid_reset_outputs", 64'(got_vec(1)), 64'h0);
    rst_n = 1'b1; req[1] = 1'b0; fr = 1'b0; acks = 0;
    repeat (6) begin
      tick();
      acks += int'(ack_w[1]);
    end
    check("mid_reset_no_ack", 64'(acks), 64'd0);

    // Flush done never arrives: watchdog acks with error
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    fr = 1'b1; req[2] = 1'b1; ack_cyc = -1; err_at_ack = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ack_w[2]) begin
        if (ack_cyc < 0) begin ack_cyc = c + 1; err_at_ack = int'(ferr_w[2]); end
        req[2] = 1'b0;
      end
    end
    fr = 1'b0;
    check("timeout_ack_cycle", 64'(ack_cyc), 64'd19);
    check("timeout_err", 64'(err_at_ack), 64'd1);

    // Outstanding counter: simultaneous req+rsp holds, underflow is sticky
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ld_req = 1'b1; tick();
    ld_rsp = 1'b1; tick();
    ld_req = 1'b0; tick();
    check("cnt_err_after_balanced", 64'(cerr_w[0]), 64'd0);
    tick();
    check("cnt_err_underflow", 64'(cerr_w[0]), 64'd1);
    ld_rsp = 1'b0; tick();
    check("cnt_err_sticky", 64'(cerr_w[0]), 64'd1);

    // Randomized traffic with well-behaved requesters and occasional reset
    quiet = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) quiet = ($urandom_range(0, 1) == 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      ld_req = !quiet && ($urandom_range(0, 2) == 0);
      ld_rsp = !quiet && ($urandom_range(0, 2) == 0);
      wbuf   = quiet || ($urandom_range(0, 1) == 0);
      fr     = ($urandom_range(0, 2) == 0);
      fd     = ($urandom_range(0, 7) == 0);
      ir     = ($urandom_range(0, 2) == 0);
      idn    = ($urandom_range(0, 7) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        if (ack_w[k])                                    req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 3) == 0)   req[k] = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
